// File: rtl/famicom_pkg.sv
// famicom_pkg: shared constants for the Famicom controller port model.
// Latency: n/a (constants only).
// Backpressure: n/a.
package famicom_pkg;

  // Button bit positions within BTN (1 = pressed).
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int PAD_BITS    = 8;
  // Wide enough to hold the saturated count of PAD_BITS.
  localparam int SHIFT_CNT_W = 4;

endpackage

// File: rtl/famicom_pad_if.sv
// famicom_pad_if: CPU-side strobe/read signals, button inputs and pad-side serial output.
// Latency: n/a (wires only).
// Backpressure: none; master = CPU/bench side, slave = pad model.
interface famicom_pad_if;
  import famicom_pkg::*;

  logic                   OUT_0;      // CPU strobe/latch, async to CLK
  logic                   P4016_CUP;  // CPU read pulse, active-low, async to CLK
  logic [PAD_BITS-1:0]    BTN;        // 1 = pressed
  logic [1:0]             TURBO_EN;   // [0] turbo on A, [1] turbo on B
  logic                   P4016_D0;   // pad-side serial data, 0 = pressed
  logic [SHIFT_CNT_W-1:0] SHIFT_CNT;  // shifts since last load, saturating

  modport master (
    output OUT_0, P4016_CUP, BTN, TURBO_EN,
    input  P4016_D0, SHIFT_CNT
  );

  modport slave (
    input  OUT_0, P4016_CUP, BTN, TURBO_EN,
    output P4016_D0, SHIFT_CNT
  );

endinterface

// File: rtl/famicom_sync_edge.sv
// famicom_sync_edge: STAGES-deep synchronizer with reset value and rise/fall detect.
// Latency: dout follows din after STAGES clk edges; rise/fall valid in the cycle dout changes.
// Backpressure: none. Ports: clk, rst (sync, active-high), din, dout, rise, fall.
module famicom_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;   // dout delayed one cycle, for edge detect

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign dout = chain[STAGES-1];
  assign rise = dout & ~prev;
  assign fall = ~dout & prev;

endmodule

// File: rtl/famicom_pad_port.sv
// famicom_pad_port: CD4021-style 8-bit PISO pad register with optional turbo on A/B.
// Latency: SYNC_STAGES+1 CLK cycles from an OUT_0 / P4016_CUP edge to P4016_D0.
// Backpressure: none; shifts on the end (rising edge) of each read pulse.
// Ports: CLK, RST (sync, active-high), bus (slave: OUT_0, P4016_CUP, BTN, TURBO_EN in;
//        P4016_D0, SHIFT_CNT out).
module famicom_pad_port
  import famicom_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] TURBO_DIV   = 16'd3000,
  parameter logic        FILL_LEVEL  = 1'b0
) (
  input  logic         CLK,
  input  logic         RST,
  famicom_pad_if.slave bus
);

  logic stb;
  logic cup;
  logic cup_rise;
  logic unused_stb_rise;
  logic unused_stb_fall;
  logic unused_cup_fall;

  famicom_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_stb_sync (
    .clk  (CLK),
    .rst  (RST),
    .din  (bus.OUT_0),
    .dout (stb),
    .rise (unused_stb_rise),
    .fall (unused_stb_fall)
  );

  // Read line idles high, so its chain resets to 1 to avoid a false rise.
  famicom_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cup_sync (
    .clk  (CLK),
    .rst  (RST),
    .din  (bus.P4016_CUP),
    .dout (cup),
    .rise (cup_rise),
    .fall (unused_cup_fall)
  );

  // Free-running turbo modulator: tphase flips every TURBO_DIV cycles.
  logic [15:0] tcnt;
  logic        tphase;

  always_ff @(posedge CLK) begin
    if (RST) begin
      tcnt   <= 16'd0;
      tphase <= 1'b0;
    end else if (tcnt == TURBO_DIV - 16'd1) begin
      tcnt   <= 16'd0;
      tphase <= ~tphase;
    end else begin
      tcnt <= tcnt + 16'd1;
    end
  end

  // Turbo masks the press during the high phase; pad side is active-low.
  logic [PAD_BITS-1:0] btn_eff;
  logic [PAD_BITS-1:0] pad;

  always_comb begin
    btn_eff        = bus.BTN;
    btn_eff[BTN_A] = bus.BTN[BTN_A] & ~(bus.TURBO_EN[0] & tphase);
    btn_eff[BTN_B] = bus.BTN[BTN_B] & ~(bus.TURBO_EN[1] & tphase);
    pad            = ~btn_eff;
  end

  logic [PAD_BITS-1:0]    sr;
  logic [SHIFT_CNT_W-1:0] shift_cnt;

  // Strobe wins over a coincident read edge, like the 4021's parallel mode.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sr        <= '1;
      shift_cnt <= '0;
    end else if (stb) begin
      sr        <= pad;
      shift_cnt <= '0;
    end else if (cup_rise) begin
      sr <= {FILL_LEVEL, sr[PAD_BITS-1:1]};
      if (shift_cnt != SHIFT_CNT_W'(PAD_BITS)) begin
        shift_cnt <= shift_cnt + 1'b1;
      end
    end
  end

  assign bus.P4016_D0  = sr[0];
  assign bus.SHIFT_CNT = shift_cnt;

endmodule
